// File: rtl/core_pkg.sv
// Shared load-path definitions: funct3 encodings, controller states,
// and request classification helpers.
package core_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } ld_state_e;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_LB)  || (f3 == F3_LH) ||
           (f3 == F3_LW)  || (f3 == F3_LBU) ||
           (f3 == F3_LHU);
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    return ((f3[1:0] == 2'b01) && lo[0]) ||
           ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/load_ctrl_extend.sv
// Sign/zero extension of a DATA_LEN field to RES_LEN bits.
module load_ctrl_extend #(
  parameter int DATA_LEN = 8,
  parameter int RES_LEN  = 32
) (
  input  logic [DATA_LEN-1:0] data,
  input  logic                zero_ext,
  output logic [RES_LEN-1:0]  res
);

  logic fill;

  assign fill = zero_ext ? 1'b0 : data[DATA_LEN-1];
  assign res  = {{(RES_LEN-DATA_LEN){fill}}, data};

endmodule

// File: rtl/load_ctrl.sv
// Single-outstanding data-memory load sequencer with lane select/extend.
// Optional LOAD_MISALIGN_TRAP_EN rejects misaligned LH/LHU/LW requests.
module load_ctrl
  import core_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_funct3,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err
);

  localparam int CW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  ld_state_e       state_q, state_d;
  logic [XLEN-1:0] addr_q;
  logic [2:0]      f3_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_inc;
  logic            timeout;
  logic            bad;
  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic [XLEN-1:0] byte_ext;
  logic [XLEN-1:0] half_ext;
  logic [XLEN-1:0] ld_data;

`ifdef LOAD_MISALIGN_TRAP_EN
  assign bad = !f3_legal(req_funct3) ||
               misaligned(req_funct3, req_addr[1:0]);
`else
  assign bad = !f3_legal(req_funct3);
`endif

  assign cnt_inc = cnt_q + 1'b1;
  assign timeout = (MEM_TIMEOUT != 0) &&
                   (cnt_inc == CW'(MEM_TIMEOUT));

  assign byte_lane = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_lane = mem_rdata[{addr_q[1], 4'b0000} +: 16];

  load_ctrl_extend #(
    .DATA_LEN (8),
    .RES_LEN  (XLEN)
  ) u_ext_b (
    .data     (byte_lane),
    .zero_ext (f3_q[2]),
    .res      (byte_ext)
  );

  load_ctrl_extend #(
    .DATA_LEN (16),
    .RES_LEN  (XLEN)
  ) u_ext_h (
    .data     (half_lane),
    .zero_ext (f3_q[2]),
    .res      (half_ext)
  );

  always_comb begin
    ld_data = mem_rdata;
    unique case (1'b1)
      (f3_q[1:0] == 2'b00): ld_data = byte_ext;
      (f3_q[1:0] == 2'b01): ld_data = half_ext;
      default:              ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_valid) state_d = bad ? RESP : MEM;
      MEM:  if (mem_ack || timeout) state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    mem_req   = (state_q == MEM);
    rsp_valid = (state_q == RESP);
    mem_addr  = '0;
    if (state_q == MEM) mem_addr = {addr_q[XLEN-1:2], 2'b00};
  end

  // Ack wins over a timeout landing on the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      f3_q     <= '0;
      cnt_q    <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            f3_q   <= req_funct3;
            cnt_q  <= '0;
            if (bad) begin
              rsp_data <= '0;
              rsp_err  <= 1'b1;
            end
          end
        end
        MEM: begin
          cnt_q <= cnt_inc;
          if (mem_ack) begin
            rsp_data <= ld_data;
            rsp_err  <= 1'b0;
          end else if (timeout) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/load_ctrl.md
Name: load_ctrl

Overview:
- Sequences a single data-memory read for core load instructions (LB, LH, LW, LBU, LHU).
- Accepts a load request from the execute stage and issues a word-aligned read on the data-memory port.
- Selects the byte or halfword lane, then sign- or zero-extends it through the existing extend unit.
- Returns a 32-bit result to writeback with a valid/ready handshake. Sits between the execute/memory stage and the data-memory interface.

Parameters:
- XLEN, 32, data/address width
- MEM_TIMEOUT, 255, max cycles to wait for mem_ack before error (0 = no timeout)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  load request present
- req_ready  output  1  controller can accept a request
- req_addr  input  XLEN  byte address
- req_funct3  input  3  RISC-V load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- mem_req  output  1  read strobe to data memory
- mem_addr  output  XLEN  word-aligned read address
- mem_ack  input  1  memory read data valid this cycle
- mem_rdata  input  XLEN  memory read data, little-endian
- rsp_valid  output  1  result available
- rsp_ready  input  1  writeback accepts result
- rsp_data  output  XLEN  extended load result
- rsp_err  output  1  error qualifier, valid with rsp_valid

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high; it takes priority over all other inputs.
  - Reset values: state IDLE, req_ready 1, mem_req 0, mem_addr 0, rsp_valid 0, rsp_data 0, rsp_err 0.
- States: IDLE, MEM, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: register the address and funct3, then go to MEM next cycle.
  - Illegal funct3 (011, 11x): go directly to RESP with rsp_err=1 and rsp_data=0; no memory access.
- MEM:
  - mem_req=1 and mem_addr={addr[XLEN-1:2],2'b00}; both held stable until mem_ack.
  - On mem_ack: capture the extended result, go to RESP.
  - mem_ack in IDLE or RESP is ignored.
  - The wait counter increments each MEM cycle. If it reaches MEM_TIMEOUT (when nonzero), go to RESP with rsp_err=1 and rsp_data=0.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are stable.
  - On rsp_ready, return to IDLE. req_ready is 0 here, so there is no request overlap.
- Latency: request accepted at cycle N, mem_req at N+1. With mem_ack at N+1, rsp_valid is at N+2. Minimum is 3 cycles per load; the next request can be accepted the cycle after the rsp handshake.
- Lane select:
  - byte = mem_rdata[8*addr[1:0] +: 8]
  - half = mem_rdata[16*addr[1] +: 16]
  - word = mem_rdata
- Extension:
  - funct3[2]=1 selects zero extension (LBU/LHU); otherwise sign extension from bit 7 or bit 15.
  - LW passes the word through unchanged.
- Reset asserted mid-MEM: mem_req drops the next cycle; any late mem_ack is ignored.

Optional Feature:
- Macro LOAD_MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU with addr[0]=1, or LW with addr[1:0]!=0, skips MEM.
  - Goes to RESP with rsp_err=1 and rsp_data=0; mem_req is never asserted.
- Undefined:
  - Low address bits beyond the access size are ignored (LH uses addr[1] only, LW ignores addr[1:0]).
  - The access completes normally with rsp_err=0.

Decomposition:
- Shared package core_pkg:
  - Load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - Load controller state enum (IDLE/MEM/RESP).
- Sub-module: the existing extend unit, instantiated twice: DATA_LEN=8 and DATA_LEN=16, both RES_LEN=XLEN.
- Lane mux and FSM stay in load_ctrl.

Test Plan:
- LB at 0x1003, mem_rdata=0x80FF_1234, ack the next cycle -> mem_addr=0x1000, rsp_data=0xFFFF_FF80, rsp_err=0, rsp_valid 2 cycles after accept.
- LBU at 0x1003, same data -> rsp_data=0x0000_0080; LHU at 0x1002 -> 0x0000_80FF; LH at 0x1002 -> 0xFFFF_80FF.
- LW at 0x2000, mem_ack delayed 5 cycles, rsp_ready held low 3 cycles -> mem_req/mem_addr stable throughout, rsp_data=mem_rdata, req_ready=0 until handshake.
- LH at 0x1001:
  - With LOAD_MISALIGN_TRAP_EN: rsp_err=1, rsp_data=0, mem_req never high.
  - Without it: mem_addr=0x1000, lower halfword extended, rsp_err=0.
- funct3=011 -> rsp_err=1, no mem_req. No mem_ack for MEM_TIMEOUT=4 cycles -> rsp_err=1, rsp_data=0.
- reset pulsed one cycle during MEM -> next cycle mem_req=0, req_ready=1, rsp_valid=0; a mem_ack arriving afterwards produces no response.
